// File: rtl/seg_display_pkg.sv
// rtl/seg_display_pkg.sv - shared types, segment table and hex decode for seg_display_ctrl
package seg_display_pkg;

    typedef enum logic [1:0] {
        MODE_RAW   = 2'b00,
        MODE_HEX   = 2'b01,
        MODE_BLANK = 2'b10,
        MODE_LAMP  = 2'b11
    } mode_e;

    typedef enum logic {
        ST_IDLE    = 1'b0,
        ST_PENDING = 1'b1
    } wr_state_e;

    // Active-high gfedcba patterns; A, b, C, d, E, F letter forms
    localparam logic [6:0] SEG_TABLE [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

    function automatic logic [6:0] hex_to_seg(input logic [3:0] nibble);
        return SEG_TABLE[nibble];
    endfunction

endpackage

// File: rtl/seg_tick_gen.sv
// rtl/seg_tick_gen.sv - refresh tick divider and blink phase generator
module seg_tick_gen #(
    parameter int TICK_DIV    = 50000,
    parameter int BLINK_TICKS = 250
) (
    input  logic clk_i,
    input  logic reset_i,
    output logic tick_o,
    output logic blink_phase_o
);

    localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int BW = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;

    logic [TW-1:0] tick_cnt_q;
    logic [BW-1:0] blink_cnt_q;
    logic          blink_phase_q;
    logic          tick_w;

    // Tick is decoded from the counter so it lands in the terminal-count cycle
    assign tick_w        = (tick_cnt_q == TW'(TICK_DIV - 1)) && !reset_i;
    assign tick_o        = tick_w;
    assign blink_phase_o = blink_phase_q;

    // Tick divider, blink tick counter and blink phase toggle
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            tick_cnt_q    <= '0;
            blink_cnt_q   <= '0;
            blink_phase_q <= 1'b0;
        end else begin
            if (tick_w) begin
                tick_cnt_q <= '0;
                if (blink_cnt_q == BW'(BLINK_TICKS - 1)) begin
                    blink_cnt_q   <= '0;
                    blink_phase_q <= ~blink_phase_q;
                end else begin
                    blink_cnt_q <= blink_cnt_q + 1'b1;
                end
            end else begin
                tick_cnt_q <= tick_cnt_q + 1'b1;
            end
        end
    end

endmodule

// File: rtl/seg_display_ctrl.sv
// rtl/seg_display_ctrl.sv - seven-segment controller with tick-aligned frame commit
module seg_display_ctrl
    import seg_display_pkg::*;
#(
    parameter int NUM_DIGITS  = 6,
    parameter int TICK_DIV    = 50000,
    parameter int BLINK_TICKS = 250
) (
    input  logic                    CLOCK_50,
    input  logic                    reset,
    input  logic                    wr_valid,
    output logic                    wr_ready,
    input  logic [1:0]              wr_mode,
    input  logic [8*NUM_DIGITS-1:0] wr_data,
    input  logic [NUM_DIGITS-1:0]   wr_blink,
    input  logic                    wr_lzb,
    output logic [7*NUM_DIGITS-1:0] hex_n,
    output logic                    tick
);

    logic tick_w;
    logic blink_phase_w;

    seg_tick_gen #(
        .TICK_DIV   (TICK_DIV),
        .BLINK_TICKS(BLINK_TICKS)
    ) u_tick_gen (
        .clk_i        (CLOCK_50),
        .reset_i      (reset),
        .tick_o       (tick_w),
        .blink_phase_o(blink_phase_w)
    );

    assign tick = tick_w;

    wr_state_e               state_q;
    logic                    ready_q;
    mode_e                   sh_mode_q,  act_mode_q;
    logic [8*NUM_DIGITS-1:0] sh_data_q,  act_data_q;
    logic [NUM_DIGITS-1:0]   sh_blink_q, act_blink_q;
    logic                    sh_lzb_q,   act_lzb_q;

    assign wr_ready = ready_q;

    // Write handshake: capture into shadow when idle, promote to active on a tick
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            ready_q     <= 1'b1;
            sh_mode_q   <= MODE_BLANK;
            sh_data_q   <= '0;
            sh_blink_q  <= '0;
            sh_lzb_q    <= 1'b0;
            act_mode_q  <= MODE_BLANK;
            act_data_q  <= '0;
            act_blink_q <= '0;
            act_lzb_q   <= 1'b0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (wr_valid) begin
                        sh_mode_q  <= mode_e'(wr_mode);
                        sh_data_q  <= wr_data;
                        sh_blink_q <= wr_blink;
                        sh_lzb_q   <= wr_lzb;
                        state_q    <= ST_PENDING;
                        ready_q    <= 1'b0;
                    end
                end
                ST_PENDING: begin
                    if (tick_w) begin
                        act_mode_q  <= sh_mode_q;
                        act_data_q  <= sh_data_q;
                        act_blink_q <= sh_blink_q;
                        act_lzb_q   <= sh_lzb_q;
                        state_q     <= ST_IDLE;
                        ready_q     <= 1'b1;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    ready_q <= 1'b1;
                end
            endcase
        end
    end

    // zero_run[d] is set when nibble d and every nibble above it are zero
    logic [NUM_DIGITS:0]     zero_run;
    logic [7*NUM_DIGITS-1:0] seg_d;
    logic [7*NUM_DIGITS-1:0] hex_n_q;

    assign zero_run[NUM_DIGITS] = 1'b1;

    for (genvar d = 0; d < NUM_DIGITS; d++) begin : g_digit
        localparam bit CAN_BLANK = (d != 0);
        logic [3:0] nib;
        logic [6:0] seg;

        assign nib         = act_data_q[8*d +: 4];
        assign zero_run[d] = zero_run[d+1] && (nib == 4'h0);

        // Per-digit segment pattern before output inversion
        always_comb begin
            seg = 7'h00;
            unique case (act_mode_q)
                MODE_RAW:   seg = act_data_q[8*d +: 7];
                MODE_HEX:   seg = (act_lzb_q && CAN_BLANK && zero_run[d]) ? 7'h00 : hex_to_seg(nib);
                MODE_BLANK: seg = 7'h00;
                MODE_LAMP:  seg = 7'h7F;
                default:    seg = 7'h00;
            endcase
            if ((act_mode_q == MODE_RAW || act_mode_q == MODE_HEX) && act_blink_q[d] && blink_phase_w) begin
                seg = 7'h00;
            end
        end

        assign seg_d[7*d +: 7] = seg;
    end

    // Registered active-low segment outputs
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            hex_n_q <= '1;
        end else begin
            hex_n_q <= ~seg_d;
        end
    end

    assign hex_n = hex_n_q;

endmodule

// File: doc/seg_display_ctrl.md
Name: seg_display_ctrl

Overview:
- Parametrised seven-segment display controller for NUM_DIGITS digits. Successor to the fixed 6-digit, raw-segment, combinational hex mapping at the board top level.
- Adds a hex decode mode, leading-zero blanking, per-digit blink, blank and lamp-test modes, and tear-free frame commit through a valid/ready write port.
- Sits between the Computer_System PIO exports and the HEXn pins; drives active-low segment outputs directly.

Parameters:
- NUM_DIGITS, 6, number of digits driven (1..8).
- TICK_DIV, 50000, CLOCK_50 cycles per refresh tick (1 ms at 50 MHz). Frame commits happen only on a tick.
- BLINK_TICKS, 250, refresh ticks per blink half-period (2 Hz blink).

Ports:
- CLOCK_50  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- wr_valid  in  1  write request.
- wr_ready  out  1  controller can accept a new frame.
- wr_mode  in  2  00 raw, 01 hex, 10 blank, 11 lamp test.
- wr_data  in  8*NUM_DIGITS  one byte per digit, digit0 = [7:0]. Raw mode: bits[6:0] are the segments gfedcba, active-high. Hex mode: bits[3:0] are the nibble.
- wr_blink  in  NUM_DIGITS  per-digit blink enable.
- wr_lzb  in  1  leading-zero blanking enable (hex mode only).
- hex_n  out  7*NUM_DIGITS  active-low segments, digit d = [7d+6:7d].
- tick  out  1  one-cycle pulse on each refresh tick (for software pacing).

Behaviour:
- Clock and reset: one clock, CLOCK_50. Reset is synchronous and active-high.
- Reset values:
  - Tick counter 0, blink counter 0, blink_phase 0.
  - pending 0, wr_ready 1, tick 0.
  - Active frame: mode blank, data 0, blink 0, lzb 0.
  - hex_n all ones (all segments off).
- Tick counter: counts 0..TICK_DIV-1 and wraps. tick = 1 in the cycle the count equals TICK_DIV-1.
- Blink counter: advances on each tick and wraps at BLINK_TICKS-1. At the wrap, blink_phase toggles.
- Write handshake (two states):
  - IDLE: wr_ready = 1. If wr_valid, capture {mode, data, blink, lzb} into the shadow register and go to PENDING.
  - PENDING: wr_ready = 0. On tick, copy shadow to active and return to IDLE.
  - Latency: the active frame changes one cycle after the tick. hex_n reflects it the cycle after that (output is registered).
  - A write accepted in the same cycle as a tick does not commit on that tick. It waits for the next tick.
  - wr_valid while wr_ready = 0 is ignored. Data is not held over.
- Segment computation, registered, per digit d:
  - Raw mode: seg = data[8d+6:8d].
  - Hex mode: seg = standard 0-F decode of data[8d+3:8d]. A and b lowercase, C uppercase, d lowercase, E and F uppercase.
  - Blank mode: seg = 0.
  - Lamp test: seg = 7'h7F. Lamp test ignores blink and lzb.
- Leading-zero blanking (hex mode, lzb = 1):
  - Digit d is blanked if its nibble and every higher digit's nibble are 0.
  - Digit 0 is never blanked. All-zero input therefore shows "0" on digit 0 only.
- Blink: if blink[d] = 1 and blink_phase = 1, seg = 0. Applies in raw and hex modes.
- Output: hex_n = ~seg.
- Reset mid-operation: a pending frame is discarded, the display goes blank, and wr_ready = 1 in the cycle after reset deasserts.
- Width rules:
  - Tick counter width = $clog2(TICK_DIV); blink counter width = $clog2(BLINK_TICKS), minimum 1.
  - TICK_DIV = 1 is legal: tick is held high and a write commits on the next cycle.

Decomposition:
- Package seg_display_pkg:
  - Mode enum (MODE_RAW, MODE_HEX, MODE_BLANK, MODE_LAMP).
  - Seven-segment constant table for 0-F.
  - Function hex_to_seg(nibble).
- One sub-module: seg_tick_gen, which holds the tick counter, the blink counter and blink_phase.
- Per-digit decode and blanking are generate loops in the top module.

Test Plan:
1. Reset then release -> hex_n = all 1s, wr_ready = 1. First tick pulse after TICK_DIV cycles (TICK_DIV = 4 in the bench).
2. Hex mode, data nibbles 5,4,3,2,1,0 (digit5..0), lzb = 0 -> after the next tick + 1 cycle:
   - digit0 hex_n = 7'h40 (0).
   - digit5 hex_n = 7'h12 (5).
   - wr_ready low from accept until the commit tick.
3. Hex mode, data = 0x000A0 nibbles, lzb = 1 -> digits 5..2 all 1s (blank), digit1 = 7'h08 (A), digit0 = 7'h40. All-zero data -> only digit0 lit.
4. Raw mode, byte 8'h7F on digit3, blink[3] = 1, BLINK_TICKS = 2 -> digit3 alternates 7'h00 and 7'h7F every 2 ticks. Other digits unaffected.
5. Write asserted in the tick cycle -> commit deferred to the following tick. A second wr_valid during PENDING is ignored: the first frame is displayed.
6. Lamp test with blink = all 1s -> hex_n all 0s constantly. Reset asserted while PENDING -> blank display, and the pending frame is never shown.
